// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: ROM request/response handshake plus the ID-stage
// queue head, stall and redirect signals.
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              o_romEnable;
    logic [ADDR_W-1:0] o_romAddr;
    logic [INST_W-1:0] i_romInst;
    logic              i_romValid;

    logic              o_instValid;
    logic [ADDR_W-1:0] o_pc;
    logic [INST_W-1:0] o_inst;
    logic              i_stall;
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirectPc;

    modport master (
        output o_romEnable,
        output o_romAddr,
        input  i_romInst,
        input  i_romValid,
        output o_instValid,
        output o_pc,
        output o_inst,
        input  i_stall,
        input  i_redirect,
        input  i_redirectPc
    );

    modport slave (
        input  o_romEnable,
        input  o_romAddr,
        output i_romInst,
        output i_romValid,
        input  o_instValid,
        input  o_pc,
        input  o_inst,
        output i_stall,
        output i_redirect,
        output i_redirectPc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: ROM valid/hold requester feeding a DEPTH-entry
// {pc, inst} prefetch queue, with stall backpressure and flushing redirect.
module inst_fetch #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_W / 8);
    localparam logic [CNT_W-1:0]  FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] w_req_addr_next;
    logic [ADDR_W-1:0] r_next_pc;
    logic [ADDR_W-1:0] w_next_pc_next;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_after;

    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [INST_W-1:0] r_q_inst [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;
    logic [ADDR_W-1:0] w_inc_addr;

    assign w_not_empty = (r_count != '0);
    assign w_inc_addr  = r_req_addr + STEP;

    // Redirect suppresses both queue operations in the cycle it is seen.
    assign w_push = (r_state == S_REQ) && bus.i_romValid && !bus.i_redirect;
    assign w_pop  = w_not_empty && !bus.i_stall && !bus.i_redirect;

    always_comb begin
        w_count_after = r_count;
        if (w_push && !w_pop) begin
            w_count_after = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_after = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_req_addr_next = r_req_addr;
        w_next_pc_next  = r_next_pc;
        if (bus.i_redirect) begin
            w_next_pc_next = bus.i_redirectPc;
            // An unanswered request cannot be withdrawn, so its response is
            // absorbed in DROP before the new address goes on the bus.
            if (((r_state == S_REQ) || (r_state == S_DROP)) && !bus.i_romValid) begin
                w_state_next = S_DROP;
            end else begin
                w_state_next    = S_REQ;
                w_req_addr_next = bus.i_redirectPc;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next    = S_REQ;
                    w_req_addr_next = RESET_PC;
                end
                S_REQ: begin
                    if (bus.i_romValid) begin
                        w_next_pc_next  = w_inc_addr;
                        w_req_addr_next = w_inc_addr;
                        w_state_next    = (w_count_after < FULL) ? S_REQ : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_pop) begin
                        w_state_next    = S_REQ;
                        w_req_addr_next = r_next_pc;
                    end
                end
                S_DROP: begin
                    if (bus.i_romValid) begin
                        w_state_next    = S_REQ;
                        w_req_addr_next = r_next_pc;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_addr <= RESET_PC;
            r_next_pc  <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_req_addr <= w_req_addr_next;
            r_next_pc  <= w_next_pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_after;
        end
    end

    // Entry storage carries no reset; o_instValid gates every read.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_q_pc[gi]   <= r_req_addr;
                    r_q_inst[gi] <= bus.i_romInst;
                end
            end
        end
    endgenerate

    assign bus.o_romEnable = (r_state == S_REQ) || (r_state == S_DROP);
    assign bus.o_romAddr   = r_req_addr;
    assign bus.o_instValid = w_not_empty;
    assign bus.o_pc        = w_not_empty ? r_q_pc[r_rd_ptr]   : '0;
    assign bus.o_inst      = w_not_empty ? r_q_inst[r_rd_ptr] : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: zero-wait and 3-cycle ROM, stall, redirect,
// address wrap from a high RESET_PC, and asynchronous reset.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   lat = 1;
    int   lat_cnt;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();
    inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus2 ();

    inst_fetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    inst_fetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // ROM model: response in the lat-th cycle of each request.
    always @(posedge clk or posedge rst) begin
        if (rst) lat_cnt <= 0;
        else if (bus.o_romEnable && !bus.i_romValid) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end
    assign bus.i_romValid  = bus.o_romEnable && (lat_cnt >= lat - 1);
    assign bus.i_romInst   = bus.o_romAddr ^ 32'hA5A5_0000;
    assign bus2.i_romValid = bus2.o_romEnable;
    assign bus2.i_romInst  = bus2.o_romAddr ^ 32'hA5A5_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_redirect = 1'b0;
        bus.i_redirectPc = '0;
        repeat (2) @(negedge clk);
        check("rst_en", 32'(bus.o_romEnable), 32'd0);
        check("rst_addr", bus.o_romAddr, 32'h0);
        check("rst_iv", 32'(bus.o_instValid), 32'd0);
        check("rst_pc", bus.o_pc, 32'h0);
        check("rst_inst", bus.o_inst, 32'h0);
        check("rst_addr_wrapdut", bus2.o_romAddr, 32'hFFFF_FFFC);
        rst = 1'b0;
    endtask

    initial begin
        bus.i_stall = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_redirectPc = '0;
        bus2.i_stall = 1'b0;
        bus2.i_redirect = 1'b0;
        bus2.i_redirectPc = '0;

        // Zero-wait ROM streaming, plus wrap past 2^32 on the second instance
        lat = 1;
        bus.i_stall = 1'b0;
        do_reset();
        cyc();
        check("zw_first_en", 32'(bus.o_romEnable), 32'd1);
        check("zw_first_addr", bus.o_romAddr, 32'h0);
        check("zw_first_iv", 32'(bus.o_instValid), 32'd0);
        check("wrap_first_addr", bus2.o_romAddr, 32'hFFFF_FFFC);
        cyc();
        for (int k = 0; k < 6; k++) begin
            check("zw_iv", 32'(bus.o_instValid), 32'd1);
            check("zw_pc", bus.o_pc, 32'(4 * k));
            check("zw_inst", bus.o_inst, 32'(4 * k) ^ 32'hA5A5_0000);
            check("zw_addr", bus.o_romAddr, 32'(4 * k + 4));
            if (k == 0) begin
                check("wrap_pc0", bus2.o_pc, 32'hFFFF_FFFC);
                check("wrap_inst0", bus2.o_inst, 32'h5A5A_FFFC);
                check("wrap_addr1", bus2.o_romAddr, 32'h0);
            end
            if (k == 1) begin
                check("wrap_pc1", bus2.o_pc, 32'h0);
                check("wrap_inst1", bus2.o_inst, 32'hA5A5_0000);
            end
            cyc();
        end

        // Stall fills the queue, then release drains one per cycle
        bus.i_stall = 1'b1;
        do_reset();
        repeat (5) cyc();
        check("full_en", 32'(bus.o_romEnable), 32'd0);
        check("full_iv", 32'(bus.o_instValid), 32'd1);
        check("full_pc", bus.o_pc, 32'h0);
        cyc();
        check("hold_en", 32'(bus.o_romEnable), 32'd0);
        check("hold_pc", bus.o_pc, 32'h0);
        check("hold_inst", bus.o_inst, 32'hA5A5_0000);
        bus.i_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("drain_pc", bus.o_pc, 32'(4 + 4 * k));
            check("drain_inst", bus.o_inst, 32'(4 + 4 * k) ^ 32'hA5A5_0000);
            if (k == 0) begin
                check("resume_en", 32'(bus.o_romEnable), 32'd1);
                check("resume_addr", bus.o_romAddr, 32'h10);
            end
        end

        // Three-cycle ROM latency
        lat = 3;
        bus.i_stall = 1'b0;
        do_reset();
        cyc();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                check("lat_en", 32'(bus.o_romEnable), 32'd1);
                check("lat_addr", bus.o_romAddr, 32'(4 * k));
                if (j == 0 && k > 0) begin
                    check("lat_iv_pulse", 32'(bus.o_instValid), 32'd1);
                    check("lat_pc", bus.o_pc, 32'(4 * (k - 1)));
                end else begin
                    check("lat_iv_idle", 32'(bus.o_instValid), 32'd0);
                end
                cyc();
            end
        end
        check("lat_addr8", bus.o_romAddr, 32'h8);
        check("lat_pc4", bus.o_pc, 32'h4);
        check("lat_iv4", 32'(bus.o_instValid), 32'd1);

        // Redirect to 0x100 during first cycle of the 0x8 request
        bus.i_redirect = 1'b1;
        bus.i_redirectPc = 32'h100;
        cyc();
        bus.i_redirect = 1'b0;
        check("drop_iv", 32'(bus.o_instValid), 32'd0);
        check("drop_en", 32'(bus.o_romEnable), 32'd1);
        check("drop_addr_a", bus.o_romAddr, 32'h8);
        cyc();
        check("drop_addr_b", bus.o_romAddr, 32'h8);
        check("drop_iv_b", 32'(bus.o_instValid), 32'd0);
        cyc();
        check("redir_addr", bus.o_romAddr, 32'h100);
        check("discard_iv", 32'(bus.o_instValid), 32'd0);
        repeat (2) cyc();
        check("redir_addr_held", bus.o_romAddr, 32'h100);
        check("redir_iv_wait", 32'(bus.o_instValid), 32'd0);
        cyc();
        check("redir_iv", 32'(bus.o_instValid), 32'd1);
        check("redir_pc", bus.o_pc, 32'h100);
        check("redir_inst", bus.o_inst, 32'hA5A5_0100);
        check("redir_next_addr", bus.o_romAddr, 32'h104);

        // Redirect coincident with push and pop at count=2
        lat = 1;
        bus.i_stall = 1'b1;
        do_reset();
        repeat (3) cyc();
        check("pre_iv", 32'(bus.o_instValid), 32'd1);
        check("pre_pc", bus.o_pc, 32'h0);
        bus.i_stall = 1'b0;
        bus.i_redirect = 1'b1;
        bus.i_redirectPc = 32'h200;
        cyc();
        bus.i_redirect = 1'b0;
        check("flush_iv", 32'(bus.o_instValid), 32'd0);
        check("flush_en", 32'(bus.o_romEnable), 32'd1);
        check("flush_addr", bus.o_romAddr, 32'h200);
        cyc();
        check("flush_pc", bus.o_pc, 32'h200);
        check("flush_inst", bus.o_inst, 32'hA5A5_0200);
        check("flush_next_addr", bus.o_romAddr, 32'h204);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check("arst_en", 32'(bus.o_romEnable), 32'd0);
        check("arst_addr", bus.o_romAddr, 32'h0);
        check("arst_iv", 32'(bus.o_instValid), 32'd0);
        check("arst_pc", bus.o_pc, 32'h0);
        check("arst_inst", bus.o_inst, 32'h0);
        check("arst_wrap_addr", bus2.o_romAddr, 32'hFFFF_FFFC);
        repeat (2) cyc();
        check("arst_hold_en", 32'(bus.o_romEnable), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
